// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce block: qualification FSM encoding and a width helper.
// Combinational only; no latency or backpressure.
package debounce_pkg;

    localparam logic ST_STABLE  = 1'b0;
    localparam logic ST_QUALIFY = 1'b1;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input; latency STAGES clocks.
// No backpressure: samples every clock, reset loads RESET_LEVEL into every stage.
module sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q <= {STAGES{RESET_LEVEL}};
        end else begin
            q <= {q[STAGES-2:0], i_d};
        end
    end

    assign o_q = q[STAGES-1];

endmodule

// File: rtl/signal_debounce.sv
// Synchronise and glitch-filter a board input; latency SYNC_STAGES clocks + FILTER_CYCLES enabled samples.
// No backpressure: i_ce only gates sampling, state holds and pulses stay low while it is low.
module signal_debounce
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 16,
    parameter logic RESET_LEVEL   = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_signal,
    input  logic i_ce,
    output logic o_signal,
    output logic o_changed,
    output logic o_glitch,
    output logic o_busy
);

    localparam int               CNT_W    = clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             s;
    logic             diff;
    logic             state;
    logic             state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             signal_nxt;
    logic             changed_nxt;
    logic             glitch_nxt;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_signal),
        .o_q   (s)
    );

    assign diff = s ^ o_signal;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_STABLE;
            cnt       <= '0;
            o_signal  <= RESET_LEVEL;
            o_changed <= 1'b0;
            o_glitch  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            o_signal  <= signal_nxt;
            o_changed <= changed_nxt;
            o_glitch  <= glitch_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        signal_nxt  = o_signal;
        changed_nxt = 1'b0;
        glitch_nxt  = 1'b0;
        if (i_ce) begin
            case (state)
                ST_STABLE: begin
                    if (diff) begin
                        // A one-sample window needs no QUALIFY pass: accept immediately.
                        if (FILTER_CYCLES == 1) begin
                            signal_nxt  = s;
                            changed_nxt = 1'b1;
                        end else begin
                            cnt_nxt   = CNT_W'(1);
                            state_nxt = ST_QUALIFY;
                        end
                    end
                end
                ST_QUALIFY: begin
                    if (!diff) begin
                        glitch_nxt = 1'b1;
                        cnt_nxt    = '0;
                        state_nxt  = ST_STABLE;
                    end else if (cnt == CNT_LAST) begin
                        signal_nxt  = s;
                        changed_nxt = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = ST_STABLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_busy = (state == ST_QUALIFY);
    end

endmodule

// File: tb/tb_signal_debounce.sv
// Scoreboard bench for signal_debounce: FILTER_CYCLES=4 and FILTER_CYCLES=1 instances.
// Expected {signal, changed, glitch, busy} per edge is queued at drive time and popped after the edge.
module tb_signal_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sig_a;
    logic ce_a;
    logic sig_b;
    logic a_signal, a_changed, a_glitch, a_busy;
    logic b_signal, b_changed, b_glitch, b_busy;

    int vectors     = 0;
    int miscompares = 0;
    logic [3:0] exp_q[$];

    signal_debounce #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .RESET_LEVEL   (1'b1)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_signal  (sig_a),
        .i_ce      (ce_a),
        .o_signal  (a_signal),
        .o_changed (a_changed),
        .o_glitch  (a_glitch),
        .o_busy    (a_busy)
    );

    signal_debounce #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (1),
        .RESET_LEVEL   (1'b1)
    ) u_dut_f1 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_signal  (sig_b),
        .i_ce      (1'b1),
        .o_signal  (b_signal),
        .o_changed (b_changed),
        .o_glitch  (b_glitch),
        .o_busy    (b_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst   = 1'b1;
        sig_a = 1'b1;
        sig_b = 1'b1;
        ce_a  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [3:0] got;
        logic [3:0] exp;
        rst   = 1'b1;
        sig_a = 1'b0;
        sig_b = 1'b0;
        ce_a  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                rst   = 1'b0;
                sig_a = 1'b1;
                sig_b = 1'b1;
            end
            exp_q.push_back(4'b1000);
            tick();
            exp = exp_q.pop_front();
            if (k == 0) continue;
            got = {a_signal, a_changed, a_glitch, a_busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_a step %0d: got %b expected %b", k, got, exp);
            end
            got = {b_signal, b_changed, b_glitch, b_busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_b step %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_accepted;
        logic [3:0] got;
        logic [3:0] exp;
        sig_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back({(k >= 6) ? 1'b0 : 1'b1, k == 6, 1'b0, (k >= 3 && k <= 5)});
            tick();
            exp = exp_q.pop_front();
            got = {a_signal, a_changed, a_glitch, a_busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL accepted edge %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_glitch;
        logic [3:0] got;
        logic [3:0] exp;
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            sig_a = (k <= 3) ? 1'b0 : 1'b1;
            exp_q.push_back({1'b1, 1'b0, k == 6, (k >= 3 && k <= 5)});
            tick();
            exp = exp_q.pop_front();
            got = {a_signal, a_changed, a_glitch, a_busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL glitch edge %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_sparse;
        logic [3:0] got;
        logic [3:0] exp;
        apply_reset();
        sig_a = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            ce_a = (k % 4 == 0);
            exp_q.push_back({(k >= 16) ? 1'b0 : 1'b1, k == 16, 1'b0, (k >= 4 && k <= 15)});
            tick();
            exp = exp_q.pop_front();
            got = {a_signal, a_changed, a_glitch, a_busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL sparse edge %0d: got %b expected %b", k, got, exp);
            end
        end
        ce_a = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic [3:0] got;
        logic [3:0] exp;
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            sig_a = (k <= 4) ? 1'b0 : 1'b1;
            rst   = (k == 5);
            exp_q.push_back({1'b1, 1'b0, 1'b0, (k == 3 || k == 4)});
            tick();
            exp = exp_q.pop_front();
            got = {a_signal, a_changed, a_glitch, a_busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_mid edge %0d: got %b expected %b", k, got, exp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_filter1;
        logic [3:0] got;
        logic [3:0] exp;
        apply_reset();
        for (int k = 1; k <= 7; k++) begin
            sig_b = (k == 1) ? 1'b0 : 1'b1;
            exp_q.push_back({(k == 3) ? 1'b0 : 1'b1, (k == 3 || k == 4), 1'b0, 1'b0});
            tick();
            exp = exp_q.pop_front();
            got = {b_signal, b_changed, b_glitch, b_busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL filter1 edge %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        sig_a = 1'b1;
        sig_b = 1'b1;
        ce_a  = 1'b1;
        test_reset();
        test_accepted();
        test_glitch();
        test_sparse();
        test_reset_mid();
        test_filter1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
